exe_stage_mem_register: RTL and testbench

- Consumer end of the ID/EXE interface. Takes the registered decode outputs (e-prefixed control, operands, immediate), performs the ALU operation, and registers the result plus the forwarded control into the EXE/MEM pipeline register (m-prefixed outputs).
- Contains an iterative 32-cycle shift-add multiplier.
- While the multiplier runs, the block raises `stall` to freeze PC, IF/ID and ID/EXE, and injects bubbles into EXE/MEM.

---
 rtl/exe_stage_mem_register.sv | 161 ++++++++++++++++
 tb/tb_exe_stage_mem_register.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_mem_register.sv
// EXE stage with EXE/MEM pipeline register: single-cycle ALU plus an iterative
// 32-step shift-add multiplier that stalls upstream stages while it runs.
module exe_stage_mem_register #(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [3:0]  ealuc,
    input  logic        ealuimm,
    input  logic [4:0]  edestReg,
    input  logic [31:0] eqa,
    input  logic [31:0] eqb,
    input  logic [31:0] eimm32,
    output logic        stall,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [4:0]  mdestReg,
    output logic [31:0] mr,
    output logic [31:0] mqb
);

    localparam int unsigned CntW = $clog2(MUL_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);
    localparam logic [3:0] AluMul = 4'b1010;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     mcand_q, mcand_d;
    logic [31:0]     mplier_q, mplier_d;
    logic [31:0]     acc_q, acc_d;

    logic            mwreg_q, mwreg_d;
    logic            mm2reg_q, mm2reg_d;
    logic            mwmem_q, mwmem_d;
    logic [4:0]      mdest_q, mdest_d;
    logic [31:0]     mr_q, mr_d;
    logic [31:0]     mqb_q, mqb_d;

    logic [31:0]     b;
    logic [31:0]     alu_r;

    assign b = ealuimm ? eimm32 : eqb;

    always_comb begin
        alu_r = '0;
        case (ealuc)
            4'b0000: alu_r = eqa + b;
            4'b0001: alu_r = eqa - b;
            4'b0010: alu_r = eqa & b;
            4'b0011: alu_r = eqa | b;
            4'b0100: alu_r = eqa ^ b;
            4'b0101: alu_r = eqa << b[4:0];
            4'b0110: alu_r = eqa >> b[4:0];
            4'b0111: alu_r = 32'($signed(eqa) >>> b[4:0]);
            4'b1000: alu_r = {31'b0, $signed(eqa) < $signed(b)};
            4'b1001: alu_r = {b[15:0], 16'b0};
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        stall    = 1'b0;
        mwreg_d  = ewreg;
        mm2reg_d = em2reg;
        mwmem_d  = ewmem;
        mdest_d  = edestReg;
        mr_d     = alu_r;
        mqb_d    = eqb;

        unique case (state_q)
            StIdle: begin
                if (ealuc == AluMul) begin
                    stall    = 1'b1;
                    mcand_d  = eqa;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                stall    = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // ID/EXE is still frozen on the MUL, so only the result differs.
                mr_d    = acc_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (stall) begin
            mwreg_d  = 1'b0;
            mm2reg_d = 1'b0;
            mwmem_d  = 1'b0;
            mdest_d  = '0;
            mr_d     = '0;
            mqb_d    = '0;
        end

        if (!resetn) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
            mdest_q  <= '0;
            mr_q     <= '0;
            mqb_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mwreg_q  <= mwreg_d;
            mm2reg_q <= mm2reg_d;
            mwmem_q  <= mwmem_d;
            mdest_q  <= mdest_d;
            mr_q     <= mr_d;
            mqb_q    <= mqb_d;
        end
    end

    assign mwreg    = mwreg_q;
    assign mm2reg   = mm2reg_q;
    assign mwmem    = mwmem_q;
    assign mdestReg = mdest_q;
    assign mr       = mr_q;
    assign mqb      = mqb_q;

endmodule

// File: tb/tb_exe_stage_mem_register.sv
// Directed bench for exe_stage_mem_register: vector table for single-cycle ALU ops,
// hand-written sequences for reset, multiply timing, back-to-back and abort.
module tb_exe_stage_mem_register;

    logic        clock = 1'b0;
    logic        resetn;
    logic        ewreg, em2reg, ewmem, ealuimm;
    logic [3:0]  ealuc;
    logic [4:0]  edestReg;
    logic [31:0] eqa, eqb, eimm32;
    logic        stall, mwreg, mm2reg, mwmem;
    logic [4:0]  mdestReg;
    logic [31:0] mr, mqb;

    int n_cmp = 0;
    int n_fail = 0;

    exe_stage_mem_register #(.MUL_CYCLES(32)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .ewreg    (ewreg),
        .em2reg   (em2reg),
        .ewmem    (ewmem),
        .ealuc    (ealuc),
        .ealuimm  (ealuimm),
        .edestReg (edestReg),
        .eqa      (eqa),
        .eqb      (eqb),
        .eimm32   (eimm32),
        .stall    (stall),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mwmem    (mwmem),
        .mdestReg (mdestReg),
        .mr       (mr),
        .mqb      (mqb)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  aluc;
        logic        aluimm;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] imm;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  dest;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [3:0] aluc, input logic aluimm,
                                input logic [31:0] qa, input logic [31:0] qb,
                                input logic [31:0] imm, input logic wreg,
                                input logic m2reg, input logic wmem,
                                input logic [4:0] dest, input logic [31:0] exp_r);
        vec_t v;
        v.aluc = aluc; v.aluimm = aluimm; v.qa = qa; v.qb = qb; v.imm = imm;
        v.wreg = wreg; v.m2reg = m2reg; v.wmem = wmem; v.dest = dest; v.exp_r = exp_r;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] aluc, input logic aluimm, input logic [31:0] qa,
                         input logic [31:0] qb, input logic [31:0] imm, input logic wreg,
                         input logic m2reg, input logic wmem, input logic [4:0] dest);
        ealuc = aluc; ealuimm = aluimm; eqa = qa; eqb = qb; eimm32 = imm;
        ewreg = wreg; em2reg = m2reg; ewmem = wmem; edestReg = dest;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        drive(v.aluc, v.aluimm, v.qa, v.qb, v.imm, v.wreg, v.m2reg, v.wmem, v.dest);
        #1;
        check($sformatf("vec%0d_stall", idx), {31'b0, stall}, 32'd0);
        step();
        check($sformatf("vec%0d_mr", idx), mr, v.exp_r);
        check($sformatf("vec%0d_mwreg", idx), {31'b0, mwreg}, {31'b0, v.wreg});
        check($sformatf("vec%0d_mm2reg", idx), {31'b0, mm2reg}, {31'b0, v.m2reg});
        check($sformatf("vec%0d_mwmem", idx), {31'b0, mwmem}, {31'b0, v.wmem});
        check($sformatf("vec%0d_mdest", idx), {27'b0, mdestReg}, {27'b0, v.dest});
        check($sformatf("vec%0d_mqb", idx), mqb, v.qb);
    endtask

    // Drives a MUL, counts stall cycles, checks bubbles and the DONE write.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] bb,
                          input logic [4:0] dest, input logic [31:0] exp_r);
        int cnt;
        logic bubble_bad;
        drive(4'b1010, 1'b0, a, bb, 32'h0, 1'b1, 1'b1, 1'b0, dest);
        #1;
        cnt = 0;
        bubble_bad = 1'b0;
        while (stall && cnt < 40) begin
            cnt++;
            step();
            if (mwreg || mm2reg || mwmem || mdestReg != 5'd0 || mr != 32'd0 || mqb != 32'd0)
                bubble_bad = 1'b1;
            // Operand A must come from the latched copy, not the live input.
            if (cnt == 3) eqa = 32'hDEAD_BEEF;
        end
        check({tag, "_stall_cycles"}, cnt, 33);
        check({tag, "_bubbles"}, {31'b0, bubble_bad}, 32'd0);
        step();
        check({tag, "_mr"}, mr, exp_r);
        check({tag, "_mwreg"}, {31'b0, mwreg}, 32'd1);
        check({tag, "_mm2reg"}, {31'b0, mm2reg}, 32'd1);
        check({tag, "_mdest"}, {27'b0, mdestReg}, {27'b0, dest});
        check({tag, "_mqb"}, mqb, bb);
    endtask

    initial begin
        logic bad;

        vecs[0]  = mk(4'b0000, 1'b1, 32'd5, 32'h11, 32'hFFFF_FFFF, 1, 0, 0, 5'd9, 32'd4);
        vecs[1]  = mk(4'b0001, 1'b0, 32'd3, 32'd5, 32'h0, 1, 0, 0, 5'd1, 32'hFFFF_FFFE);
        vecs[2]  = mk(4'b0010, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 1, 1, 0, 5'd2,
                      32'h00F0_00F0);
        vecs[3]  = mk(4'b0011, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 0, 0, 1, 5'd3,
                      32'hFFF0_FFF0);
        vecs[4]  = mk(4'b0100, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 1, 0, 0, 5'd4,
                      32'hFF00_FF00);
        vecs[5]  = mk(4'b0101, 1'b0, 32'd1, 32'h25, 32'h0, 1, 0, 0, 5'd5, 32'h20);
        vecs[6]  = mk(4'b0110, 1'b0, 32'h8000_0000, 32'd4, 32'h0, 1, 0, 0, 5'd6, 32'h0800_0000);
        vecs[7]  = mk(4'b0111, 1'b0, 32'h8000_0000, 32'd4, 32'h0, 1, 0, 0, 5'd7, 32'hF800_0000);
        vecs[8]  = mk(4'b1000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1, 0, 0, 5'd8, 32'd1);
        vecs[9]  = mk(4'b1000, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, 5'd10, 32'd0);
        vecs[10] = mk(4'b1001, 1'b1, 32'd0, 32'h77, 32'h1234, 1, 0, 0, 5'd11, 32'h1234_0000);
        vecs[11] = mk(4'b1011, 1'b0, 32'd9, 32'd9, 32'h0, 1, 0, 0, 5'd12, 32'd0);
        vecs[12] = mk(4'b1111, 1'b0, 32'd9, 32'd9, 32'h0, 1, 0, 0, 5'd31, 32'd0);

        // Reset held with a MUL presented: no stall, outputs cleared.
        resetn = 1'b0;
        drive(4'b1010, 1'b0, 32'd7, 32'd6, 32'h0, 1'b1, 1'b1, 1'b1, 5'd3);
        step();
        step();
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_mr", mr, 32'd0);
        check("rst_mwreg", {31'b0, mwreg}, 32'd0);
        check("rst_mm2reg", {31'b0, mm2reg}, 32'd0);
        check("rst_mwmem", {31'b0, mwmem}, 32'd0);
        check("rst_mdest", {27'b0, mdestReg}, 32'd0);
        check("rst_mqb", mqb, 32'd0);
        resetn = 1'b1;
        #1;
        check("rst_release_stall", {31'b0, stall}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            apply_vec(i, vecs[i]);
        end

        do_mul("mul_basic", 32'd7, 32'd6, 5'd3, 32'd42);
        do_mul("mul_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'd1);
        do_mul("mul_b2b", 32'h0001_0000, 32'h0001_0000, 5'd5, 32'd0);
        apply_vec(100, mk(4'b0000, 1'b0, 32'd1, 32'd1, 32'h0, 1, 0, 0, 5'd6, 32'd2));

        // Abort a multiply at BUSY iteration 10.
        drive(4'b1010, 1'b0, 32'd3, 32'd5, 32'h0, 1'b1, 1'b0, 1'b0, 5'd7);
        #1;
        step();
        repeat (10) step();
        check("abort_busy_stall", {31'b0, stall}, 32'd1);
        resetn = 1'b0;
        #1;
        check("abort_rst_stall", {31'b0, stall}, 32'd0);
        step();
        check("abort_mr", mr, 32'd0);
        check("abort_mwreg", {31'b0, mwreg}, 32'd0);
        check("abort_mdest", {27'b0, mdestReg}, 32'd0);
        resetn = 1'b1;
        drive(4'b0000, 1'b0, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        check("abort_idle_stall", {31'b0, stall}, 32'd0);
        bad = 1'b0;
        repeat (40) begin
            step();
            if (stall || mwreg || mr == 32'd15 || mdestReg != 5'd0) bad = 1'b1;
        end
        check("abort_no_result", {31'b0, bad}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
